// File: rtl/knn_ctrl_pkg.sv
// Shared definitions for the KNN sequencer: default sizes, FSM state
// encodings and the distance value the sorter loads into empty slots.
package knn_ctrl_pkg;

    localparam int KNN_W      = 32;
    localparam int KNN_K      = 10;
    localparam int KNN_ADDR_W = 8;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CLR    = 4'd1,
        FETCH  = 4'd2,
        FEED0  = 4'd3,
        FEED1  = 4'd4,
        DRAIN0 = 4'd5,
        DRAIN1 = 4'd6,
        READ   = 4'd7,
        FIN    = 4'd8
    } state_t;

    // A cleared sorter slot holds the largest representable distance.
    localparam logic [KNN_W-1:0] SORTER_ALL_ONES = '1;

endpackage

// File: rtl/knn_ctrl.sv
// KNN sequencer: streams every dataset point from the coordinate memory
// into the distance/insertion sorter, then freezes the sorter and hands the
// K nearest indices out over a valid/ready stream, nearest first.
module knn_ctrl
    import knn_ctrl_pkg::*;
#(
    parameter int W      = KNN_W,
    parameter int K      = KNN_K,
    parameter int ADDR_W = KNN_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   n_points,
    input  logic [W/2-1:0]    test_x,
    input  logic [W/2-1:0]    test_y,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [W/2-1:0]    mem_x,
    input  logic [W/2-1:0]    mem_y,
    output logic              srt_clr,
    output logic              srt_valid,
    output logic              srt_done,
    output logic [3:0]        srt_sel,
    output logic [W/2-1:0]    srt_x1,
    output logic [W/2-1:0]    srt_y1,
    output logic [W/2-1:0]    srt_x2,
    output logic [W/2-1:0]    srt_y2,
    input  logic [W/4-1:0]    srt_idx,
    output logic [W/4-1:0]    idx_out,
    output logic              idx_valid,
    input  logic              idx_ready
);

    // The point counter is one bit wider than the address so a full
    // 2^ADDR_W dataset can be counted without wrapping before exit.
    localparam int            NW  = ADDR_W + 1;
    localparam logic [NW-1:0] K_N = NW'(K);

    state_t          state;
    state_t          state_next;
    logic [W/2-1:0]  test_x_q;
    logic [W/2-1:0]  test_y_q;
    logic [NW-1:0]   n_q;
    logic [NW-1:0]   p_q;
    logic [3:0]      r_q;
    logic [NW-1:0]   p_inc;
    logic [NW-1:0]   r_inc;
    logic [NW-1:0]   out_count;

    assign p_inc     = p_q + NW'(1);
    assign r_inc     = NW'(r_q) + NW'(1);
    assign out_count = (n_q < K_N) ? n_q : K_N;

    assign mem_addr = p_q[ADDR_W-1:0];
    assign srt_x1   = test_x_q;
    assign srt_y1   = test_y_q;
    assign srt_x2   = mem_x;
    assign srt_y2   = mem_y;

    // State register; reset abandons any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the request on an accepted start, advance point and read counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            test_x_q <= '0;
            test_y_q <= '0;
            n_q      <= '0;
            p_q      <= '0;
            r_q      <= '0;
        end else begin
            if (state == IDLE && start) begin
                test_x_q <= test_x;
                test_y_q <= test_y;
                n_q      <= n_points;
                p_q      <= '0;
                r_q      <= '0;
            end
            if (state == FEED1) begin
                p_q <= p_inc;
            end
            if (state == READ && idx_ready) begin
                r_q <= r_q + 4'd1;
            end
        end
    end

    // Next-state and output decode; the sorter stays frozen unless feeding or draining.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        mem_en     = 1'b0;
        srt_clr    = 1'b0;
        srt_valid  = 1'b0;
        srt_done   = 1'b0;
        srt_sel    = '0;
        idx_valid  = 1'b0;
        idx_out    = '0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                srt_done = 1'b1;
                if (start) begin
                    state_next = CLR;
                end
            end
            CLR: begin
                srt_clr    = 1'b1;
                srt_done   = 1'b1;
                state_next = (n_q == '0) ? FIN : FETCH;
            end
            FETCH: begin
                mem_en     = 1'b1;
                state_next = FEED0;
            end
            FEED0: begin
                srt_valid  = 1'b1;
                state_next = FEED1;
            end
            FEED1: begin
                srt_valid  = 1'b1;
                state_next = (p_inc == n_q) ? DRAIN0 : FETCH;
            end
            DRAIN0: begin
                state_next = DRAIN1;
            end
            DRAIN1: begin
                state_next = READ;
            end
            READ: begin
                srt_done  = 1'b1;
                srt_sel   = r_q;
                idx_valid = 1'b1;
                idx_out   = srt_idx;
                if (idx_ready && r_inc == out_count) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                busy       = 1'b0;
                done       = 1'b1;
                srt_done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                srt_done   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_knn_ctrl.sv
// Bench for knn_ctrl: behavioural coordinate memory and insertion sorter
// around the controller, with a scoreboard of hand-computed index streams.
module tb_knn_ctrl;
    import knn_ctrl_pkg::*;

    localparam int W      = 32;
    localparam int K      = 10;
    localparam int ADDR_W = 8;
    localparam int HW     = W / 2;
    localparam int IW     = W / 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   n_points;
    logic [HW-1:0]     test_x;
    logic [HW-1:0]     test_y;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [HW-1:0]     mem_x;
    logic [HW-1:0]     mem_y;
    logic              srt_clr;
    logic              srt_valid;
    logic              srt_done;
    logic [3:0]        srt_sel;
    logic [HW-1:0]     srt_x1;
    logic [HW-1:0]     srt_y1;
    logic [HW-1:0]     srt_x2;
    logic [HW-1:0]     srt_y2;
    logic [IW-1:0]     srt_idx;
    logic [IW-1:0]     idx_out;
    logic              idx_valid;
    logic              idx_ready;

    knn_ctrl #(.W(W), .K(K), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points),
        .test_x(test_x), .test_y(test_y), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y),
        .srt_clr(srt_clr), .srt_valid(srt_valid), .srt_done(srt_done),
        .srt_sel(srt_sel), .srt_x1(srt_x1), .srt_y1(srt_y1),
        .srt_x2(srt_x2), .srt_y2(srt_y2), .srt_idx(srt_idx),
        .idx_out(idx_out), .idx_valid(idx_valid), .idx_ready(idx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coordinate memory: one-cycle read latency, output held while disabled.
    logic [HW-1:0] mem_xa [256];
    logic [HW-1:0] mem_ya [256];

    always @(posedge clk) begin
        if (mem_en) begin
            mem_x <= mem_xa[mem_addr];
            mem_y <= mem_ya[mem_addr];
        end
    end

    // Sorter model: squared distance, strict-less insertion, one commit per two valid cycles.
    longint slot_d [K];
    int     slot_i [K];
    longint nd     [K];
    int     ni     [K];
    int     ins_cnt;
    bit     phase;
    longint dx, dy, ins_d;
    int     pos;
    bit     found;

    always_comb begin
        dx    = longint'($signed(srt_x1)) - longint'($signed(srt_x2));
        dy    = longint'($signed(srt_y1)) - longint'($signed(srt_y2));
        ins_d = dx * dx + dy * dy;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < K; k++) begin
            nd[k] = slot_d[k];
            ni[k] = slot_i[k];
        end
        for (int k = 0; k < K; k++) begin
            if (!found && ins_d < slot_d[k]) begin
                found = 1'b1;
                pos   = k;
            end
        end
        if (found) begin
            for (int k = 1; k < K; k++) begin
                if (k > pos) begin
                    nd[k] = slot_d[k-1];
                    ni[k] = slot_i[k-1];
                end
            end
            nd[pos] = ins_d;
            ni[pos] = ins_cnt;
        end
    end

    always @(posedge clk) begin
        if (srt_clr) begin
            for (int k = 0; k < K; k++) begin
                slot_d[k] <= longint'(SORTER_ALL_ONES);
                slot_i[k] <= 0;
            end
            ins_cnt <= 0;
            phase   <= 1'b0;
        end else if (srt_valid && !srt_done) begin
            phase <= !phase;
            if (phase) begin
                for (int k = 0; k < K; k++) begin
                    slot_d[k] <= nd[k];
                    slot_i[k] <= ni[k];
                end
                ins_cnt <= ins_cnt + 1;
            end
        end
    end

    assign srt_idx = (srt_sel < 4'(K)) ? IW'(slot_i[srt_sel]) : '0;

    int checks;
    int errors;
    int exp_q [$];
    int exp_v;
    int cyc;
    int clr_cnt, feed_cnt, busy_cnt, done_cnt, hs_cyc, done_cyc;
    bit valid_seen;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setPoint(input int i, input int x, input int y);
        mem_xa[i] = HW'(x);
        mem_ya[i] = HW'(y);
    endtask

    task automatic applyStimulus(input int n, input int tx, input int ty);
        clr_cnt    = 0;
        feed_cnt   = 0;
        busy_cnt   = 0;
        done_cnt   = 0;
        valid_seen = 1'b0;
        @(posedge clk);
        #1;
        n_points = n[ADDR_W:0];
        test_x   = tx[HW-1:0];
        test_y   = ty[HW-1:0];
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            if (done_cnt != 0) break;
        end
        checkOutput({name, " done seen"}, (done_cnt != 0) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " mem_en"}, mem_en, 0);
        checkOutput({tag, " mem_addr"}, mem_addr, 0);
        checkOutput({tag, " srt_valid"}, srt_valid, 0);
        checkOutput({tag, " srt_done"}, srt_done, 1);
        checkOutput({tag, " srt_clr"}, srt_clr, 0);
        checkOutput({tag, " srt_sel"}, srt_sel, 0);
        checkOutput({tag, " idx_valid"}, idx_valid, 0);
        checkOutput({tag, " idx_out"}, idx_out, 0);
    endtask

    initial begin
        int vcnt;
        checks = 0; errors = 0; cyc = 0;
        clr_cnt = 0; feed_cnt = 0; busy_cnt = 0; done_cnt = 0;
        hs_cyc = 0; done_cyc = 0; valid_seen = 1'b0;
        rst = 1'b0; start = 1'b0; idx_ready = 1'b1;
        n_points = '0; test_x = '0; test_y = '0;

        // Monitor: counts protocol events and pops the scoreboard on each handshake.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (rst) begin
                    if (srt_clr) clr_cnt++;
                    if (busy) busy_cnt++;
                    if (mem_en || srt_valid) feed_cnt++;
                    if (idx_valid) valid_seen = 1'b1;
                    if (done) begin
                        done_cnt++;
                        done_cyc = cyc;
                    end
                    if (idx_valid && idx_ready) begin
                        hs_cyc = cyc;
                        if (exp_q.size() == 0) begin
                            checkOutput("unexpected idx", idx_out, -1);
                        end else begin
                            exp_v = exp_q.pop_front();
                            checkOutput("idx stream", idx_out, exp_v);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("por");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Three points around the origin: distances 25, 2, 4.
        $display("[TB] case 1: three points");
        setPoint(0, 3, 4); setPoint(1, 1, 1); setPoint(2, 0, 2);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        applyStimulus(3, 0, 0);
        waitDone(200, "t1");
        checkOutput("t1 pending", exp_q.size(), 0);
        checkOutput("t1 feed cycles", feed_cnt, 9);
        checkOutput("t1 clr pulses", clr_cnt, 1);
        checkOutput("t1 done count", done_cnt, 1);
        checkOutput("t1 done latency", done_cyc - hs_cyc, 1);
        checkOutput("t1 busy cycles", busy_cnt, 15);

        // Twelve points at decreasing distance: only the nearest ten come out.
        $display("[TB] case 2: twelve points, K limit");
        for (int i = 0; i < 12; i++) setPoint(i, 12 - i, 0);
        for (int i = 11; i >= 2; i--) exp_q.push_back(i);
        applyStimulus(12, 0, 0);
        waitDone(500, "t2");
        checkOutput("t2 pending", exp_q.size(), 0);
        checkOutput("t2 feed cycles", feed_cnt, 36);
        checkOutput("t2 busy cycles", busy_cnt, 49);
        checkOutput("t2 done latency", done_cyc - hs_cyc, 1);
        checkOutput("t2 done count", done_cnt, 1);

        // Empty dataset: clear then finish, no output.
        $display("[TB] case 3: empty dataset");
        applyStimulus(0, 0, 0);
        waitDone(50, "t3");
        checkOutput("t3 clr pulses", clr_cnt, 1);
        checkOutput("t3 busy cycles", busy_cnt, 1);
        checkOutput("t3 idx_valid seen", valid_seen, 0);
        checkOutput("t3 feed cycles", feed_cnt, 0);
        checkOutput("t3 done count", done_cnt, 1);

        // Backpressure on the first output.
        $display("[TB] case 4: stalled consumer");
        setPoint(0, 5, 0); setPoint(1, 2, 0); setPoint(2, 3, 0); setPoint(3, 1, 0);
        exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        idx_ready = 1'b0;
        applyStimulus(4, 0, 0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (idx_valid) break;
        end
        checkOutput("t4 valid reached", idx_valid, 1);
        for (int s = 0; s < 5; s++) begin
            checkOutput("t4 stall valid", idx_valid, 1);
            checkOutput("t4 stall idx", idx_out, 3);
            @(posedge clk);
            #1;
        end
        idx_ready = 1'b1;
        waitDone(200, "t4");
        checkOutput("t4 pending", exp_q.size(), 0);
        checkOutput("t4 done count", done_cnt, 1);

        // Reset in the middle of the fifth point's second feed cycle.
        $display("[TB] case 5: reset mid-run");
        for (int i = 0; i < 8; i++) setPoint(i, 0, 0);
        applyStimulus(8, 0, 0);
        vcnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (srt_valid) vcnt++;
            if (vcnt == 10) break;
        end
        checkOutput("t5 reached feed", vcnt, 10);
        #2 rst = 1'b0;
        #1 checkResetOutputs("t5 async");
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t5 no done", done_cnt, 0);
        checkOutput("t5 no idx", valid_seen, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        setPoint(0, 2, 2); setPoint(1, 0, 1); setPoint(2, 1, 0);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        applyStimulus(3, 0, 0);
        waitDone(200, "t5");
        checkOutput("t5 pending", exp_q.size(), 0);
        checkOutput("t5 clr pulses", clr_cnt, 1);
        checkOutput("t5 busy cycles", busy_cnt, 15);
        checkOutput("t5 done count", done_cnt, 1);

        // Second start while busy, with two equidistant points.
        $display("[TB] case 6: ignored start and tie order");
        setPoint(0, 2, 2); setPoint(1, 5, 5); setPoint(2, 0, 0);
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(1);
        applyStimulus(3, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        n_points = 9'd1; test_x = 16'd5; test_y = 16'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(200, "t6");
        checkOutput("t6 pending", exp_q.size(), 0);
        checkOutput("t6 clr pulses", clr_cnt, 1);
        checkOutput("t6 busy cycles", busy_cnt, 15);
        checkOutput("t6 done count", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
